// File: rtl/neg_edge_detector_if.sv
// Bus bundle for neg_edge_detector: the monitored lines and the falling-edge pulses.
interface neg_edge_detector_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] signal;
  logic [WIDTH-1:0] neg_edge;

  // Source side drives the monitored lines and consumes the pulses.
  modport master (
    output signal,
    input  neg_edge
  );

  // Detector side samples the lines and produces the pulses.
  modport slave (
    input  signal,
    output neg_edge
  );
endinterface

// File: rtl/neg_edge_detector.sv
// Falling-edge detector: WIDTH independent channels, optional input
// synchronizer, one-clock registered pulse per detected 1->0 transition.
module neg_edge_detector #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  neg_edge_detector_if.slave  bus
);

  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] neg_edge_q;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

      // Synchronizer shift chain; stage 0 captures the raw input.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= bus.signal;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s_in = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign s_in = bus.signal;
    end
  endgenerate

  // Previous-sample register and registered edge pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q        <= '0;
      neg_edge_q <= '0;
    end else begin
      s_q        <= s_in;
      neg_edge_q <= s_q & ~s_in;
    end
  end

  assign bus.neg_edge = neg_edge_q;

endmodule

// File: tb/tb_neg_edge_detector.sv
// Randomized self-checking bench for neg_edge_detector, three configurations
// sharing one clock/reset, checked against a history-based reference model.
module tb_neg_edge_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  neg_edge_detector_if #(.WIDTH(1)) if0 ();
  neg_edge_detector_if #(.WIDTH(4)) if1 ();
  neg_edge_detector_if #(.WIDTH(4)) if2 ();

  neg_edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  neg_edge_detector #(.WIDTH(4), .SYNC_STAGES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  neg_edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [3:0] sig;
  assign if0.signal = sig[0];
  assign if1.signal = sig;
  assign if2.signal = sig;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Values present at each rising edge, indexed by edge number.
  logic [3:0] sig_hist[$];
  logic       rst_hist[$];

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, sig_hist.size() - 1);
    end
  endtask

  // Input as seen by the detector at edge k: raw input from s edges earlier,
  // forced to 0 if a reset occurred while it was travelling through the chain.
  function automatic logic [3:0] delayed_in(int k, int s);
    if (k - s < 0) return 4'b0000;
    for (int j = k - s; j < k; j++)
      if (rst_hist[j]) return 4'b0000;
    return sig_hist[k - s];
  endfunction

  // Expected pulse after edge k: a fall between the detector's views at edges
  // k-1 and k, with no reset at either edge.
  function automatic logic [3:0] expected(int k, int s, logic [3:0] mask);
    logic [3:0] prev, cur;
    if (rst_hist[k]) return 4'b0000;
    if (k < 1 || rst_hist[k-1]) prev = 4'b0000;
    else prev = delayed_in(k - 1, s);
    cur = delayed_in(k, s);
    return prev & ~cur & mask;
  endfunction

  // One clock cycle: drive mid-cycle, optional sub-cycle glitch, then check
  // all three instances shortly after the rising edge.
  task automatic step(input logic [3:0] s, input logic r, input bit glitch);
    int k;
    @(negedge clk);
    sig   = s;
    rst_n = r;
    if (glitch) begin
      #1 sig = ~s;
      #1 sig = s;
    end
    @(posedge clk);
    sig_hist.push_back(sig);
    rst_hist.push_back(!rst_n);
    k = sig_hist.size() - 1;
    #1;
    check("w1_s0", {3'b000, if0.neg_edge}, expected(k, 0, 4'b0001));
    check("w4_s0", if1.neg_edge, expected(k, 0, 4'b1111));
    check("w4_s2", if2.neg_edge, expected(k, 2, 4'b1111));
  endtask

  initial begin
    sig = 4'b0000;

    // Reset with input held low, then release: no pulses.
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Single fall, then held low and a rise.
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);

    // Per-bit independence: 1111 -> 0101 -> 0000.
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Back-to-back falls.
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b1, 1'b0);

    // Reset asserted during a pulse, released with the input low.
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Fall coinciding with reset release.
    step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Glitches between edges stay invisible.
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);

    // Random traffic with occasional resets and glitches.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), ($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
